// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised VGA timing generator with incremental,
// multiplier-free video-memory addressing and a sync/blank pipeline
// aligned to the memory read latency.
module vga_scan_engine #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned BPC         = 1,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic              vga_clock,
    input  logic              resetn,
    input  logic [3*BPC-1:0]  pixel_colour,
    output logic [ADDR_W-1:0] memory_address,
    output logic [9:0]        VGA_R,
    output logic [9:0]        VGA_G,
    output logic [9:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK,
    output logic              VGA_SYNC,
    output logic              VGA_CLK,
    output logic              frame_start,
    output logic              vblank
);

    localparam int unsigned H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W          = $clog2(H_TOTAL + 1);
    localparam int unsigned VC_W          = $clog2(V_TOTAL + 1);
    localparam int unsigned H_SYNC_START  = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END    = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START  = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END    = V_SYNC_START + V_SYNC;
    localparam int unsigned DOTS_PER_LINE = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned SUB_MASK      = (1 << SCALE_SHIFT) - 1;
    localparam int unsigned PIPE_D        = MEM_LATENCY + 1;

    logic [HC_W-1:0]   r_hc;
    logic [VC_W-1:0]   r_vc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_vblank;

    logic [PIPE_D-1:0] r_hs_pipe;
    logic [PIPE_D-1:0] r_vs_pipe;
    logic [PIPE_D-1:0] r_blank_pipe;
    logic [PIPE_D-1:0] r_fs_pipe;

    logic [9:0]        r_red;
    logic [9:0]        r_green;
    logic [9:0]        r_blue;

    logic [HC_W-1:0]   w_hc_next;
    logic [VC_W-1:0]   w_vc_next;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_line_vis;
    logic              w_pix_vis;
    logic              w_last_line;
    logic              w_dot_end;
    logic              w_row_end;
    logic              w_hs_lvl;
    logic              w_vs_lvl;
    logic              w_frame_origin;
    logic [BPC-1:0]    w_r;
    logic [BPC-1:0]    w_g;
    logic [BPC-1:0]    w_b;
    logic [9:0]        w_r_exp;
    logic [9:0]        w_g_exp;
    logic [9:0]        w_b_exp;

    assign w_h_last       = (r_hc == HC_W'(H_TOTAL - 1));
    assign w_v_last       = (r_vc == VC_W'(V_TOTAL - 1));
    assign w_line_vis     = (r_vc < VC_W'(V_ACTIVE));
    assign w_pix_vis      = w_line_vis && (r_hc < HC_W'(H_ACTIVE));
    assign w_last_line    = (r_vc == VC_W'(V_ACTIVE - 1));
    assign w_dot_end      = ((r_hc & HC_W'(SUB_MASK)) == HC_W'(SUB_MASK));
    assign w_row_end      = ((r_vc & VC_W'(SUB_MASK)) == VC_W'(SUB_MASK));
    assign w_frame_origin = (r_hc == '0) && (r_vc == '0);
    assign w_hs_lvl = ((r_hc >= HC_W'(H_SYNC_START)) && (r_hc < HC_W'(H_SYNC_END))) ? HS_POL : ~HS_POL;
    assign w_vs_lvl = ((r_vc >= VC_W'(V_SYNC_START)) && (r_vc < VC_W'(V_SYNC_END))) ? VS_POL : ~VS_POL;

    // Next scan position: hc wraps every line, vc steps on hc wrap
    always_comb begin
        w_hc_next = r_hc + HC_W'(1);
        w_vc_next = r_vc;
        if (w_h_last) begin
            w_hc_next = '0;
            w_vc_next = w_v_last ? '0 : r_vc + VC_W'(1);
        end
    end

    // Scan counters, vblank flag and incremental address generator
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_hc       <= '0;
            r_vc       <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_vblank   <= 1'b0;
        end else begin
            r_hc     <= w_hc_next;
            r_vc     <= w_vc_next;
            r_vblank <= (w_vc_next >= VC_W'(V_ACTIVE));
            if (w_h_last && w_v_last) begin
                r_addr     <= '0;
                r_row_base <= '0;
            end else if (w_line_vis) begin
                if (w_h_last) begin
                    // Repeat the row until its last replicated line; the final
                    // visible row never advances so the address stays in range
                    if (!w_row_end) begin
                        r_addr <= r_row_base;
                    end else if (!w_last_line) begin
                        r_row_base <= r_row_base + ADDR_W'(DOTS_PER_LINE);
                        r_addr     <= r_row_base + ADDR_W'(DOTS_PER_LINE);
                    end
                end else if (w_dot_end && (r_hc < HC_W'(H_ACTIVE - 1))) begin
                    // The last dot of a line holds so blanking keeps a valid address
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Sync/blank/frame markers delayed to line up with memory read data
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_hs_pipe    <= {PIPE_D{~HS_POL}};
            r_vs_pipe    <= {PIPE_D{~VS_POL}};
            r_blank_pipe <= '0;
            r_fs_pipe    <= '0;
        end else begin
            r_hs_pipe    <= {r_hs_pipe[PIPE_D-2:0], w_hs_lvl};
            r_vs_pipe    <= {r_vs_pipe[PIPE_D-2:0], w_vs_lvl};
            r_blank_pipe <= {r_blank_pipe[PIPE_D-2:0], w_pix_vis};
            r_fs_pipe    <= {r_fs_pipe[PIPE_D-2:0], w_frame_origin};
        end
    end

    assign w_r = pixel_colour[3*BPC-1 -: BPC];
    assign w_g = pixel_colour[2*BPC-1 -: BPC];
    assign w_b = pixel_colour[BPC-1:0];

    // Replicate each channel MSB-first across the 10-bit DAC width
    for (genvar gi = 0; gi < 10; gi++) begin : g_expand
        assign w_r_exp[9-gi] = w_r[BPC-1-(gi%BPC)];
        assign w_g_exp[9-gi] = w_g[BPC-1-(gi%BPC)];
        assign w_b_exp[9-gi] = w_b[BPC-1-(gi%BPC)];
    end

    // Colour stage: pass expanded colour in the visible region, black elsewhere
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (r_blank_pipe[PIPE_D-2]) begin
            r_red   <= w_r_exp;
            r_green <= w_g_exp;
            r_blue  <= w_b_exp;
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign memory_address = r_addr;
    assign VGA_R          = r_red;
    assign VGA_G          = r_green;
    assign VGA_B          = r_blue;
    assign VGA_HS         = r_hs_pipe[PIPE_D-1];
    assign VGA_VS         = r_vs_pipe[PIPE_D-1];
    assign VGA_BLANK      = r_blank_pipe[PIPE_D-1];
    assign frame_start    = r_fs_pipe[PIPE_D-1];
    assign vblank         = r_vblank;
    assign VGA_SYNC       = 1'b1;
    assign VGA_CLK        = vga_clock;

endmodule
